md_sched: RTL and testbench

- E-stage multiply/divide sequencer for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo, owns the HI/LO registers and models the fixed multi-cycle latency with a busy counter.
- Raises a stall request to the hazard logic while a D-stage MD instruction would collide with an in-flight operation.
- Sits beside the ALU in E; md_op comes from the instruction decoder.

---
 rtl/md_sched_pkg.sv | 34 +++
 rtl/md_arith.sv | 75 +++++++
 rtl/md_sched.sv | 119 +++++++++++
 tb/tb_md_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared MD opcode constants, default latencies and the sequencer state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_sched_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

   // True for the opcodes that occupy the unit for multiple cycles.
   function automatic logic md_is_arith(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the multiply opcodes (selects the shorter latency).
   function automatic logic md_is_mult(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply/divide core producing the next {hi,lo}.
// Latency: zero cycles (purely combinational).
// Backpressure: none; divide by zero returns the current {hi,lo} unchanged.
module md_arith
   import md_sched_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] cur_hi,
   input  logic [W-1:0] cur_lo,
   output logic [W-1:0] hi_next,
   output logic [W-1:0] lo_next
);

   logic signed [2*W-1:0] prod_s;
   logic        [2*W-1:0] prod_u;
   logic signed [W-1:0]   quo_s;
   logic signed [W-1:0]   rem_s;
   logic        [W-1:0]   quo_u;
   logic        [W-1:0]   rem_u;
   logic        [W-1:0]   divisor;
   logic                  div_zero;

   // Widen operands to 2W so the truncated 2W product is exact in both signedness modes.
   always_comb begin
      prod_s = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};
   end

   // Divisor is forced to 1 on zero so the dividers never see 0; that result is discarded anyway.
   always_comb begin
      div_zero = (b == '0);
      divisor  = div_zero ? {{(W-1){1'b0}}, 1'b1} : b;
      quo_s    = $signed(a) / $signed(divisor);
      rem_s    = $signed(a) % $signed(divisor);
      quo_u    = a / divisor;
      rem_u    = a % divisor;
   end

   // Select the result for the requested opcode; non-arith opcodes hold the current value.
   always_comb begin
      hi_next = cur_hi;
      lo_next = cur_lo;
      case (op)
         MD_MULT: begin
            hi_next = prod_s[2*W-1:W];
            lo_next = prod_s[W-1:0];
         end
         MD_MULTU: begin
            hi_next = prod_u[2*W-1:W];
            lo_next = prod_u[W-1:0];
         end
         MD_DIV: begin
            if (!div_zero) begin
               hi_next = rem_s;
               lo_next = quo_s;
            end
         end
         MD_DIVU: begin
            if (!div_zero) begin
               hi_next = rem_u;
               lo_next = quo_u;
            end
         end
         default: begin
            hi_next = cur_hi;
            lo_next = cur_lo;
         end
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// E-stage mult/div sequencer owning HI/LO; models fixed latency with a busy counter.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles; MTHI/MTLO one edge; MFHI/MFLO combinational.
// Backpressure: stall_md holds a D-stage MD instruction while an operation launches or is in flight.
module md_sched
   import md_sched_pkg::*;
#(
   parameter int W           = 32,
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [3:0]   md_op,
   input  logic         start,
   input  logic [W-1:0] rs_data,
   input  logic [W-1:0] rt_data,
   input  logic         d_is_md,
   output logic         busy,
   output logic [W-1:0] md_rdata,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         stall_md
);

   localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

   md_state_t    state_q, state_nx;
   logic [3:0]   cnt_q, cnt_nx;
   logic [W-1:0] hi_q, hi_nx;
   logic [W-1:0] lo_q, lo_nx;
   logic [W-1:0] pend_hi_q, pend_hi_nx;
   logic [W-1:0] pend_lo_q, pend_lo_nx;
   logic [W-1:0] ar_hi, ar_lo;
   logic         launch;

   // The result is computed at launch and parked until the counter expires.
   md_arith #(.W(W)) u_arith (
      .op      (md_op),
      .a       (rs_data),
      .b       (rt_data),
      .cur_hi  (hi_q),
      .cur_lo  (lo_q),
      .hi_next (ar_hi),
      .lo_next (ar_lo)
   );

   assign launch = start && md_is_arith(md_op);

   // State, counter, HI/LO and pending-result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         state_q   <= state_nx;
         cnt_q     <= cnt_nx;
         hi_q      <= hi_nx;
         lo_q      <= lo_nx;
         pend_hi_q <= pend_hi_nx;
         pend_lo_q <= pend_lo_nx;
      end
   end

   // Next-state: launch/move-to in IDLE, count down in BUSY and commit on the last cycle.
   always_comb begin
      state_nx   = state_q;
      cnt_nx     = cnt_q;
      hi_nx      = hi_q;
      lo_nx      = lo_q;
      pend_hi_nx = pend_hi_q;
      pend_lo_nx = pend_lo_q;
      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               pend_hi_nx = ar_hi;
               pend_lo_nx = ar_lo;
               cnt_nx     = md_is_mult(md_op) ? MULT_LAT : DIV_LAT;
               state_nx   = ST_BUSY;
            end else if (start && (md_op == MD_MTHI)) begin
               hi_nx = rs_data;
            end else if (start && (md_op == MD_MTLO)) begin
               lo_nx = rs_data;
            end
         end
         ST_BUSY: begin
            cnt_nx = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_nx = ST_IDLE;
               hi_nx    = pend_hi_q;
               lo_nx    = pend_lo_q;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   // Read port and stall request; stall is held low while in reset.
   always_comb begin
      busy     = (state_q == ST_BUSY);
      hi       = hi_q;
      lo       = lo_q;
      md_rdata = '0;
      if (md_op == MD_MFHI) begin
         md_rdata = hi_q;
      end else if (md_op == MD_MFLO) begin
         md_rdata = lo_q;
      end
      stall_md = reset_n && d_is_md && (busy || launch);
   end

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;
   import md_sched_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [3:0]  md_op;
   logic        start;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        d_is_md;
   logic        busy;
   logic [31:0] md_rdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall_md;

   int checks = 0;
   int errors = 0;

   // Reference HI/LO kept by the bench.
   logic [31:0] m_hi, m_lo;

   md_sched dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .md_op    (md_op),
      .start    (start),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .d_is_md  (d_is_md),
      .busy     (busy),
      .md_rdata (md_rdata),
      .hi       (hi),
      .lo       (lo),
      .stall_md (stall_md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          cyc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural reference using 64-bit integer arithmetic.
   function automatic logic [63:0] ref_arith(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up, uq, ur;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = {h, l};
      if (op == MD_MULT) begin
         sp = sa * sb;
         r  = sp;
      end else if (op == MD_MULTU) begin
         up = ua * ub;
         r  = up;
      end else if (op == MD_DIV && b != 0) begin
         sq = sa / sb;
         sr = sa % sb;
         r  = {sr[31:0], sq[31:0]};
      end else if (op == MD_DIVU && b != 0) begin
         uq = ua / ub;
         ur = ua % ub;
         r  = {ur[31:0], uq[31:0]};
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      md_op   = MD_NONE;
      start   = 1'b0;
      d_is_md = 1'b0;
   endtask

   // MTHI/MTLO; busy must never rise.
   task automatic move_to(input logic [3:0] op, input logic [31:0] val);
      md_op = op; start = 1'b1; rs_data = val; d_is_md = 1'b0;
      #1;
      tick();
      idle_inputs();
      #1;
      chk("mt_no_busy", {31'd0, busy}, 32'd0);
      if (op == MD_MTHI) m_hi = val; else m_lo = val;
   endtask

   task automatic read_check(input string name, input logic [3:0] op, input logic [31:0] exp);
      md_op = op; start = 1'b1;
      #1;
      chk(name, md_rdata, exp);
      tick();
      idle_inputs();
      #1;
   endtask

   // Launch an arith op, check stall during launch and each busy cycle, count busy cycles.
   task automatic run_arith(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_cyc, input bit rand_d);
      logic [63:0] exp;
      int          n;
      logic        d;
      exp   = ref_arith(op, a, b, m_hi, m_lo);
      md_op = op; start = 1'b1; rs_data = a; rt_data = b; d_is_md = 1'b1;
      #1;
      chk({name, "_stall_launch"}, {31'd0, stall_md}, 32'd1);
      tick();
      md_op = MD_NONE; start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         d = rand_d ? 1'($urandom_range(0, 1)) : 1'b1;
         d_is_md = d;
         #1;
         chk({name, "_stall_busy"}, {31'd0, stall_md}, {31'd0, d});
         tick();
         n++;
      end
      chk({name, "_busy_cycles"}, n, exp_cyc);
      d_is_md = 1'b1;
      #1;
      chk({name, "_stall_after"}, {31'd0, stall_md}, 32'd0);
      d_is_md = 1'b0;
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      chk({name, "_hi"}, hi, m_hi);
      chk({name, "_lo"}, lo, m_lo);
   endtask

   initial begin
      vecs[0] = '{"mult",    MD_MULT,  32'hFFFFFFFE, 32'd3, 32'd0,  32'd0,  32'hFFFFFFFF, 32'hFFFFFFFA, 5};
      vecs[1] = '{"multu",   MD_MULTU, 32'hFFFFFFFE, 32'd3, 32'd0,  32'd0,  32'h00000002, 32'hFFFFFFFA, 5};
      vecs[2] = '{"div",     MD_DIV,   32'hFFFFFFF9, 32'd2, 32'd0,  32'd0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3] = '{"divu",    MD_DIVU,  32'd7,        32'd2, 32'd0,  32'd0,  32'd1,        32'd3,        10};
      vecs[4] = '{"divzero", MD_DIVU,  32'd5,        32'd0, 32'h11, 32'h22, 32'h11,       32'h22,       10};
      vecs[5] = '{"mult45",  MD_MULT,  32'd4,        32'd5, 32'h7,  32'h9,  32'd0,        32'd20,       5};

      reset_n = 1'b0;
      idle_inputs();
      rs_data = '0; rt_data = '0;
      m_hi = '0; m_lo = '0;
      #12;
      d_is_md = 1'b1;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_stall", {31'd0, stall_md}, 32'd0);
      chk("rst_rdata", md_rdata, 32'd0);
      d_is_md = 1'b0;
      #3;
      reset_n = 1'b1;
      tick();

      // Test-plan vectors.
      for (int i = 0; i < 6; i++) begin
         move_to(MD_MTHI, vecs[i].pre_hi);
         move_to(MD_MTLO, vecs[i].pre_lo);
         run_arith(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].cyc, 1'b0);
         chk({vecs[i].name, "_vec_hi"}, hi, vecs[i].exp_hi);
         chk({vecs[i].name, "_vec_lo"}, lo, vecs[i].exp_lo);
      end

      // Stall must follow d_is_md while busy.
      run_arith("stall_mix", MD_DIV, 32'd100, 32'hFFFFFFFD, 10, 1'b1);

      // Move-to then move-from.
      move_to(MD_MTHI, 32'hABCD);
      read_check("mfhi", MD_MFHI, 32'hABCD);
      move_to(MD_MTLO, 32'h1234);
      read_check("mflo", MD_MFLO, 32'h1234);
      chk("mf_busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of cycle 3 of a MULT.
      move_to(MD_MTHI, 32'h55);
      move_to(MD_MTLO, 32'h66);
      md_op = MD_MULT; start = 1'b1; rs_data = 32'd9; rt_data = 32'd9;
      #1;
      tick();
      idle_inputs();
      tick();
      tick();
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      m_hi = '0; m_lo = '0;
      tick();
      reset_n = 1'b1;
      tick();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      run_arith("mult_after_rst", MD_MULT, 32'd4, 32'd5, 5, 1'b0);
      chk("mult_after_rst_lo20", lo, 32'd20);

      // Randomized ops against the reference model.
      for (int i = 0; i < 60; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = 4'($urandom_range(0, 8));
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
              ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (md_is_arith(op)) begin
            run_arith("rnd_arith", op, a, b, md_is_mult(op) ? 5 : 10, 1'b1);
         end else if (op == MD_MTHI || op == MD_MTLO) begin
            move_to(op, a);
            chk("rnd_mt_hi", hi, m_hi);
            chk("rnd_mt_lo", lo, m_lo);
         end else if (op == MD_MFHI) begin
            read_check("rnd_mfhi", MD_MFHI, m_hi);
         end else if (op == MD_MFLO) begin
            read_check("rnd_mflo", MD_MFLO, m_lo);
         end else begin
            // Non-started or NONE op must leave state untouched.
            md_op = 4'($urandom_range(1, 6)); start = 1'b0; rs_data = a; rt_data = b;
            #1;
            tick();
            idle_inputs();
            #1;
            chk("rnd_nostart_busy", {31'd0, busy}, 32'd0);
            chk("rnd_nostart_hi", hi, m_hi);
            chk("rnd_nostart_lo", lo, m_lo);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
